// File: rtl/rms_seq_ctrl.sv
// RMS sequencer: squares and sums a 2**LOG2N sample window, shifts the sum down to the mean, then takes a bit-serial floor square root.
// Latency: the result is valid WIDTH cycles after the last sample is accepted. Backpressure: input is stalled through SQRT/DONE; DONE holds the result until out_ready.
// Build option RMS_SIGNED_EN: treat in_data as two's complement and accumulate |in_data|.
module rms_seq_ctrl #(
    parameter int WIDTH = 8,
    parameter int LOG2N = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_rms,
    output logic             busy
);

    localparam int AW = 2*WIDTH + LOG2N;
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {S_ACC, S_SQRT, S_DONE} state_t;

    state_t             state, state_nxt;
    logic [AW-1:0]      acc, acc_nxt;
    logic [LOG2N-1:0]   cnt, cnt_nxt;
    logic [2*WIDTH-1:0] mean, mean_nxt;
    logic [WIDTH-1:0]   root, root_nxt;
    logic [BW-1:0]      bit_idx, bit_idx_nxt;

    logic [WIDTH-1:0]   mag;
    logic [WIDTH-1:0]   trial;
    logic [2*WIDTH-1:0] sq;
    logic [2*WIDTH-1:0] trial_sq;
    logic [AW-1:0]      acc_sum;

    // Negating the most negative value wraps to 2**(WIDTH-1), which is the correct magnitude.
`ifdef RMS_SIGNED_EN
    assign mag = in_data[WIDTH-1] ? (WIDTH'(0) - in_data) : in_data;
`else
    assign mag = in_data;
`endif

    assign sq       = {{WIDTH{1'b0}}, mag} * {{WIDTH{1'b0}}, mag};
    assign acc_sum  = acc + {{LOG2N{1'b0}}, sq};
    assign trial    = root | (WIDTH'(1) << bit_idx);
    assign trial_sq = {{WIDTH{1'b0}}, trial} * {{WIDTH{1'b0}}, trial};
    assign out_rms  = root;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_ACC;
            acc     <= '0;
            cnt     <= '0;
            mean    <= '0;
            root    <= '0;
            bit_idx <= '0;
        end else begin
            state   <= state_nxt;
            acc     <= acc_nxt;
            cnt     <= cnt_nxt;
            mean    <= mean_nxt;
            root    <= root_nxt;
            bit_idx <= bit_idx_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        acc_nxt     = acc;
        cnt_nxt     = cnt;
        mean_nxt    = mean;
        root_nxt    = root;
        bit_idx_nxt = bit_idx;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = (state != S_ACC) || (cnt != '0);

        case (state)
            S_ACC: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    acc_nxt = acc_sum;
                    // The final sample leaves cnt at its top value; only the DONE handshake clears it.
                    if (cnt == '1) begin
                        mean_nxt    = acc_sum[LOG2N +: 2*WIDTH];
                        root_nxt    = '0;
                        bit_idx_nxt = BW'(WIDTH-1);
                        state_nxt   = S_SQRT;
                    end else begin
                        cnt_nxt = cnt + LOG2N'(1);
                    end
                end
            end
            S_SQRT: begin
                if (trial_sq <= mean)
                    root_nxt = trial;
                bit_idx_nxt = bit_idx - BW'(1);
                if (bit_idx == '0)
                    state_nxt = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    acc_nxt   = '0;
                    cnt_nxt   = '0;
                    state_nxt = S_ACC;
                end
            end
            default: begin
                state_nxt = S_ACC;
            end
        endcase
    end

endmodule

// File: tb/tb_rms_seq_ctrl.sv
// Directed and randomized checks of rms_seq_ctrl at WIDTH=8, LOG2N=4.
module tb_rms_seq_ctrl;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_rms;
    logic       busy;

    int checks = 0;
    int errors = 0;

    rms_seq_ctrl #(.WIDTH(8), .LOG2N(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_rms   (out_rms),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // All tasks start and end at 1ns after a rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_sample(input logic [7:0] x, input int gap);
        bit was_rdy;
        bit done;
        done = 0;
        in_valid = 1'b0;
        repeat (gap) step();
        in_valid = 1'b1;
        in_data  = x;
        for (int i = 0; i < 200; i++) begin
            was_rdy = in_ready;
            step();
            if (was_rdy) begin
                done = 1;
                break;
            end
        end
        in_valid = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL push_timeout: sample %0d not accepted within 200 cycles", x);
        end
    endtask

    task automatic push_const(input logic [7:0] x);
        for (int i = 0; i < 16; i++) push_sample(x, 0);
    endtask

    task automatic wait_valid();
        bit seen;
        seen = 0;
        for (int i = 0; i < 64; i++) begin
            if (out_valid) begin
                seen = 1;
                break;
            end
            step();
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL wait_valid_timeout: out_valid=%0b after 64 cycles, want 1", out_valid);
        end
    endtask

    task automatic take_result(output logic [7:0] r);
        wait_valid();
        r = out_rms;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    function automatic int ref_rms(input logic [7:0] s[16], input bit sgn);
        int sum;
        int mean;
        int a;
        int r;
        sum = 0;
        for (int i = 0; i < 16; i++) begin
            a = int'(s[i]);
            if (sgn && s[i][7]) a = 256 - a;
            sum += a * a;
        end
        mean = sum / 16;
        r = 0;
        while ((r + 1) * (r + 1) <= mean) r++;
        return r;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
        checks++; if (out_rms !== 8'd0) begin errors++; $display("FAIL reset_out_rms: got %0d want 0", out_rms); end
    endtask

    task automatic test_latency();
        logic exp_v;
        out_ready = 1'b1;
        push_sample(8'd3, 0);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL lat_busy_acc: got %0b want 1", busy); end
        for (int i = 1; i < 16; i++) push_sample(8'd3, 0);
        for (int e = 1; e <= 8; e++) begin
            step();
            exp_v = (e == 8);
            checks++; if (out_valid !== exp_v) begin errors++; $display("FAIL lat_out_valid_edge%0d: got %0b want %0b", e, out_valid, exp_v); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL lat_in_ready_edge%0d: got %0b want 0", e, in_ready); end
        end
        checks++; if (out_rms !== 8'd3) begin errors++; $display("FAIL lat_rms: got %0d want 3", out_rms); end
        step();
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lat_after_hs_valid: got %0b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL lat_after_hs_ready: got %0b want 1", in_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL lat_after_hs_busy: got %0b want 0", busy); end
    endtask

    task automatic test_max();
        logic [7:0] r;
        push_const(8'd255);
        take_result(r);
        checks++; if (r !== 8'd255) begin errors++; $display("FAIL max_rms: got %0d want 255", r); end
    endtask

    task automatic test_floor();
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            push_sample(8'd0, 0);
            push_sample(8'd255, 0);
        end
        take_result(r);
        checks++; if (r !== 8'd180) begin errors++; $display("FAIL floor_rms: got %0d want 180", r); end
    endtask

    task automatic test_hold();
        logic [7:0] r;
        out_ready = 1'b0;
        push_const(8'd5);
        wait_valid();
        // Producer presents a sample the whole time; none may be taken.
        in_valid = 1'b1;
        in_data  = 8'd200;
        for (int i = 0; i < 5; i++) begin
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL hold_valid_c%0d: got %0b want 1", i, out_valid); end
            checks++; if (out_rms !== 8'd5) begin errors++; $display("FAIL hold_rms_c%0d: got %0d want 5", i, out_rms); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_in_ready_c%0d: got %0b want 0", i, in_ready); end
            step();
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL hold_release_valid: got %0b want 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hold_release_busy: got %0b want 0", busy); end
        push_const(8'd2);
        take_result(r);
        checks++; if (r !== 8'd2) begin errors++; $display("FAIL hold_next_rms: got %0d want 2", r); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] r;
        push_const(8'd9);
        step();
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %0b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready: got %0b want 1", in_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %0b want 0", busy); end
        push_const(8'd7);
        take_result(r);
        checks++; if (r !== 8'd7) begin errors++; $display("FAIL rstmid_rms: got %0d want 7", r); end
    endtask

    task automatic test_signed();
        logic [7:0] r;
        logic [7:0] exp_r;
`ifdef RMS_SIGNED_EN
        exp_r = 8'd4;
`else
        exp_r = 8'd252;
`endif
        push_const(8'hFC);
        take_result(r);
        checks++; if (r !== exp_r) begin errors++; $display("FAIL signed_rms: got %0d want %0d", r, exp_r); end
    endtask

    task automatic test_random();
        logic [7:0] s[16];
        logic [7:0] r;
        int         exp_r;
        bit         sgn;
`ifdef RMS_SIGNED_EN
        sgn = 1;
`else
        sgn = 0;
`endif
        for (int w = 0; w < 100; w++) begin
            for (int i = 0; i < 16; i++) begin
                case ($urandom_range(0, 7))
                    0:       s[i] = 8'h80;
                    1:       s[i] = 8'hFF;
                    2:       s[i] = 8'h00;
                    default: s[i] = 8'($urandom_range(0, 255));
                endcase
            end
            exp_r = ref_rms(s, sgn);
            for (int i = 0; i < 16; i++) push_sample(s[i], int'($urandom_range(0, 2)));
            wait_valid();
            repeat ($urandom_range(0, 3)) step();
            take_result(r);
            checks++;
            if (r !== 8'(exp_r)) begin
                errors++;
                $display("FAIL random_w%0d: got %0d want %0d", w, r, exp_r);
            end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'd0;
        out_ready = 1'b0;
        test_reset();
        test_latency();
        test_max();
        test_floor();
        test_hold();
        test_reset_mid();
        test_signed();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
